// File: rtl/jk_mod_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : jk_mod_counter_if
// Brief    : Control/status bundle between a mod-N JK counter and its user.
//            The master drives enable/direction/load; the slave (counter)
//            returns count, complement, JK excitation and status flags.
// Revision : 1.0
// ============================================================================
interface jk_mod_counter_if #(
  parameter int W = 4
);
  logic         EN;
  logic         UP;
  logic         LD;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic [W-1:0] QN;
  logic [W-1:0] JV;
  logic [W-1:0] KV;
  logic         TC;
  logic         CO;
  logic         ERR;

  modport master (
    output EN, UP, LD, D,
    input  Q, QN, JV, KV, TC, CO, ERR
  );

  modport slave (
    input  EN, UP, LD, D,
    output Q, QN, JV, KV, TC, CO, ERR
  );
endinterface
`default_nettype wire

// File: rtl/jk_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : jk_mod_counter
// Brief    : Synchronous mod-MODULUS up/down counter with per-bit J/K
//            excitation outputs for a downstream JK cell bank, terminal
//            count, registered wrap pulse and sticky illegal-load flag.
// Revision : 1.0
// ============================================================================
module jk_mod_counter #(
  parameter int W       = 4,
  parameter int MODULUS = 10
) (
  input  wire logic         CLK,
  input  wire logic         CLR,
  jk_mod_counter_if.slave   bus
);

  // Reject moduli that cannot be represented or counted in W bits.
  generate
    if ((MODULUS < 2) || (MODULUS > (2 ** W))) begin : g_bad_modulus
      $error("jk_mod_counter: MODULUS %0d outside legal range 2..2^%0d", MODULUS, W);
    end
  endgenerate

  // Top value of the count range; with MODULUS == 2^W this is all ones.
  localparam logic [W-1:0] c_TOP     = W'(MODULUS - 1);
  localparam logic [W-1:0] c_ONE     = W'(1);
  // Load-range limit held one bit wider so MODULUS == 2^W stays representable.
  localparam logic [W:0]   c_MOD_EXT = (W + 1)'(MODULUS);

  logic [W-1:0] r_q;
  logic [W-1:0] r_qn;
  logic         r_co;
  logic         r_err;

  logic [W-1:0] w_n;
  logic         w_tc;
  logic         w_ld_bad;
  logic         w_at_top;
  logic         w_at_zero;

  assign w_at_top  = (r_q == c_TOP);
  assign w_at_zero = (r_q == '0);

  // Next-state selection: load beats count, count beats hold.
  always_comb begin
    w_n      = r_q;
    w_tc     = 1'b0;
    w_ld_bad = 1'b0;
    if (bus.LD) begin
      if ({1'b0, bus.D} < c_MOD_EXT) begin
        w_n = bus.D;
      end else begin
        w_n      = '0;
        w_ld_bad = 1'b1;
      end
    end else if (bus.EN) begin
      if (bus.UP) begin
        w_tc = w_at_top;
        w_n  = w_at_top ? '0 : (r_q + c_ONE);
      end else begin
        w_tc = w_at_zero;
        w_n  = w_at_zero ? c_TOP : (r_q - c_ONE);
      end
    end
  end

  // State registers; the JK bank downstream resets to zero alongside these.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_q   <= '0;
      r_qn  <= '1;
      r_co  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_q   <= w_n;
      r_qn  <= ~w_n;
      r_co  <= w_tc;
      r_err <= r_err | w_ld_bad;
    end
  end

  // Set only bits that rise, reset only bits that fall; others hold (J=K=0).
  assign bus.JV  = w_n & ~r_q;
  assign bus.KV  = ~w_n & r_q;
  assign bus.TC  = w_tc;
  assign bus.Q   = r_q;
  assign bus.QN  = r_qn;
  assign bus.CO  = r_co;
  assign bus.ERR = r_err;

endmodule
`default_nettype wire

// File: tb/tb_jk_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_mod_counter
// Brief    : Self-checking bench for jk_mod_counter (W=4, MODULUS=10) against
//            an arithmetic modulo reference and a modelled JK cell bank.
// Revision : 1.0
// ============================================================================
module tb_jk_mod_counter;

  localparam int M = 10;

  logic CLK = 1'b0;
  logic CLR = 1'b0;

  always #5 CLK = ~CLK;

  jk_mod_counter_if #(.W(4)) bus ();

  jk_mod_counter #(.W(4), .MODULUS(M)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state
  int         m_q   = 0;
  bit         m_err = 1'b0;
  bit         m_co  = 1'b0;
  logic [3:0] m_cell = 4'h0;

  function automatic int ref_next(bit en, bit up, bit ld, int d, int q);
    if (ld) return (d < M) ? d : 0;
    if (en) return up ? (q + 1) % M : (q + M - 1) % M;
    return q;
  endfunction

  function automatic bit ref_tc(bit en, bit up, bit ld, int q);
    return en && !ld && ((up && q == M - 1) || (!up && q == 0));
  endfunction

  task automatic model_reset();
    m_q = 0; m_err = 1'b0; m_co = 1'b0; m_cell = 4'h0;
  endtask

  task automatic drive(bit en, bit up, bit ld, logic [3:0] d);
    @(negedge CLK);
    bus.EN = en; bus.UP = up; bus.LD = ld; bus.D = d;
    #1;
  endtask

  // Advance one edge: JK cell bank clocks in the excitation seen before it.
  task automatic tick();
    logic [3:0] jv, kv;
    int n;
    bit tc;
    jv = bus.JV; kv = bus.KV;
    n  = ref_next(bus.EN, bus.UP, bus.LD, int'(bus.D), m_q);
    tc = ref_tc(bus.EN, bus.UP, bus.LD, m_q);
    if (bus.LD && int'(bus.D) >= M) m_err = 1'b1;
    @(posedge CLK);
    for (int i = 0; i < 4; i++)
      m_cell[i] = (jv[i] & ~m_cell[i]) | (~kv[i] & m_cell[i]);
    m_q  = n;
    m_co = tc;
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b0;
    bus.EN = 1'b1; bus.UP = 1'b1; bus.LD = 1'b0; bus.D = 4'h0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      checks += 4;
      if (bus.Q !== 4'h0)  begin errors++; $display("FAIL reset_q: got %h expected 0", bus.Q); end
      if (bus.QN !== 4'hF) begin errors++; $display("FAIL reset_qn: got %h expected f", bus.QN); end
      if (bus.CO !== 1'b0) begin errors++; $display("FAIL reset_co: got %b expected 0", bus.CO); end
      if (bus.ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.ERR); end
    end
    CLR = 1'b1;
    drive(1, 1, 0, 4'h0);
    tick();
    checks += 2;
    if (bus.Q !== 4'h1) begin errors++; $display("FAIL first_edge_q: got %h expected 1", bus.Q); end
    if (bus.CO !== 1'b0) begin errors++; $display("FAIL first_edge_co: got %b expected 0", bus.CO); end
  endtask

  task automatic test_up_wrap();
    drive(0, 1, 1, 4'h0);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 0, 4'h0);
      checks++;
      if (bus.TC !== (m_q == 9)) begin errors++; $display("FAIL up_tc: q=%0d got %b expected %b", m_q, bus.TC, m_q == 9); end
      if (m_q == 9) begin
        checks += 2;
        if (bus.JV !== 4'b0000) begin errors++; $display("FAIL up_jv_at9: got %b expected 0000", bus.JV); end
        if (bus.KV !== 4'b1001) begin errors++; $display("FAIL up_kv_at9: got %b expected 1001", bus.KV); end
      end
      tick();
      checks += 2;
      if (bus.Q !== 4'((k + 1) % 10)) begin errors++; $display("FAIL up_q: got %0d expected %0d", bus.Q, (k + 1) % 10); end
      if (bus.CO !== (k == 9)) begin errors++; $display("FAIL up_co: step %0d got %b expected %b", k, bus.CO, k == 9); end
    end
    drive(0, 1, 0, 4'h0);
    tick();
    checks++;
    if (bus.CO !== 1'b0) begin errors++; $display("FAIL up_co_single: got %b expected 0", bus.CO); end
  endtask

  task automatic test_down_wrap();
    drive(1, 0, 0, 4'h0);
    checks += 3;
    if (bus.TC !== 1'b1)    begin errors++; $display("FAIL down_tc: got %b expected 1", bus.TC); end
    if (bus.JV !== 4'b1001) begin errors++; $display("FAIL down_jv: got %b expected 1001", bus.JV); end
    if (bus.KV !== 4'b0000) begin errors++; $display("FAIL down_kv: got %b expected 0000", bus.KV); end
    tick();
    checks += 2;
    if (bus.Q !== 4'd9)  begin errors++; $display("FAIL down_q9: got %0d expected 9", bus.Q); end
    if (bus.CO !== 1'b1) begin errors++; $display("FAIL down_co: got %b expected 1", bus.CO); end
    drive(1, 0, 0, 4'h0);
    tick();
    checks += 2;
    if (bus.Q !== 4'd8)  begin errors++; $display("FAIL down_q8: got %0d expected 8", bus.Q); end
    if (bus.CO !== 1'b0) begin errors++; $display("FAIL down_co_clear: got %b expected 0", bus.CO); end
  endtask

  task automatic test_load();
    drive(1, 1, 1, 4'd7);
    checks++;
    if (bus.TC !== 1'b0) begin errors++; $display("FAIL load_tc: got %b expected 0", bus.TC); end
    tick();
    checks += 3;
    if (bus.Q !== 4'd7)   begin errors++; $display("FAIL load_q7: got %0d expected 7", bus.Q); end
    if (bus.CO !== 1'b0)  begin errors++; $display("FAIL load_co: got %b expected 0", bus.CO); end
    if (bus.ERR !== 1'b0) begin errors++; $display("FAIL load_err0: got %b expected 0", bus.ERR); end
    drive(0, 1, 1, 4'd12);
    tick();
    checks += 2;
    if (bus.Q !== 4'd0)   begin errors++; $display("FAIL bad_load_q: got %0d expected 0", bus.Q); end
    if (bus.ERR !== 1'b1) begin errors++; $display("FAIL bad_load_err: got %b expected 1", bus.ERR); end
    drive(0, 1, 1, 4'd3);
    tick();
    checks += 2;
    if (bus.Q !== 4'd3)   begin errors++; $display("FAIL relo_q: got %0d expected 3", bus.Q); end
    if (bus.ERR !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus.ERR); end
    // Load while already at the wrap value: load must suppress TC and CO.
    drive(0, 1, 1, 4'd9);
    tick();
    drive(1, 1, 1, 4'd9);
    checks++;
    if (bus.TC !== 1'b0) begin errors++; $display("FAIL load_prio_tc: got %b expected 0", bus.TC); end
    tick();
    checks += 2;
    if (bus.Q !== 4'd9)  begin errors++; $display("FAIL load_prio_q: got %0d expected 9", bus.Q); end
    if (bus.CO !== 1'b0) begin errors++; $display("FAIL load_prio_co: got %b expected 0", bus.CO); end
  endtask

  task automatic test_hold();
    logic [3:0] q0;
    q0 = bus.Q;
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'($urandom_range(0, 1)), 0, 4'($urandom_range(0, 15)));
      checks += 3;
      if (bus.JV !== 4'h0) begin errors++; $display("FAIL hold_jv: got %b expected 0000", bus.JV); end
      if (bus.KV !== 4'h0) begin errors++; $display("FAIL hold_kv: got %b expected 0000", bus.KV); end
      if (bus.TC !== 1'b0) begin errors++; $display("FAIL hold_tc: got %b expected 0", bus.TC); end
      tick();
      checks++;
      if (bus.Q !== q0) begin errors++; $display("FAIL hold_q: got %0d expected %0d", bus.Q, q0); end
    end
  endtask

  task automatic test_mid_reset();
    drive(0, 1, 1, 4'd5);
    tick();
    checks++;
    if (bus.Q !== 4'd5) begin errors++; $display("FAIL mid_pre_q: got %0d expected 5", bus.Q); end
    drive(0, 1, 1, 4'd9);
    tick();
    drive(1, 1, 0, 4'h0);
    checks++;
    if (bus.TC !== 1'b1) begin errors++; $display("FAIL mid_tc_pending: got %b expected 1", bus.TC); end
    #1 CLR = 1'b0;
    #1;
    model_reset();
    checks += 4;
    if (bus.Q !== 4'h0)   begin errors++; $display("FAIL mid_q: got %0d expected 0", bus.Q); end
    if (bus.QN !== 4'hF)  begin errors++; $display("FAIL mid_qn: got %h expected f", bus.QN); end
    if (bus.CO !== 1'b0)  begin errors++; $display("FAIL mid_co: got %b expected 0", bus.CO); end
    if (bus.ERR !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", bus.ERR); end
    CLR = 1'b1;
    #1;
    tick();
    checks += 2;
    if (bus.Q !== 4'd1)  begin errors++; $display("FAIL mid_after_q: got %0d expected 1", bus.Q); end
    if (bus.CO !== 1'b0) begin errors++; $display("FAIL mid_after_co: got %b expected 0", bus.CO); end
  endtask

  task automatic test_random();
    bit en, up, ld;
    logic [3:0] d, eq;
    int n;
    for (int k = 0; k < 200; k++) begin
      en = ($urandom_range(0, 3) != 0);
      up = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 9) == 0);
      d  = 4'($urandom_range(0, 15));
      drive(en, up, ld, d);
      n  = ref_next(en, up, ld, int'(d), m_q);
      eq = 4'(m_q);
      checks += 4;
      if (bus.TC !== ref_tc(en, up, ld, m_q)) begin errors++; $display("FAIL rnd_tc: cyc %0d got %b expected %b", k, bus.TC, ref_tc(en, up, ld, m_q)); end
      if (bus.JV !== (4'(n) & ~eq)) begin errors++; $display("FAIL rnd_jv: cyc %0d got %b expected %b", k, bus.JV, 4'(n) & ~eq); end
      if (bus.KV !== (~4'(n) & eq)) begin errors++; $display("FAIL rnd_kv: cyc %0d got %b expected %b", k, bus.KV, ~4'(n) & eq); end
      if ((bus.JV & bus.KV) !== 4'h0) begin errors++; $display("FAIL rnd_jk_both: cyc %0d got %b expected 0000", k, bus.JV & bus.KV); end
      tick();
      checks += 5;
      if (bus.Q !== 4'(m_q))   begin errors++; $display("FAIL rnd_q: cyc %0d got %0d expected %0d", k, bus.Q, m_q); end
      if (bus.QN !== ~4'(m_q)) begin errors++; $display("FAIL rnd_qn: cyc %0d got %h expected %h", k, bus.QN, ~4'(m_q)); end
      if (bus.CO !== m_co)     begin errors++; $display("FAIL rnd_co: cyc %0d got %b expected %b", k, bus.CO, m_co); end
      if (bus.ERR !== m_err)   begin errors++; $display("FAIL rnd_err: cyc %0d got %b expected %b", k, bus.ERR, m_err); end
      if (m_cell !== 4'(m_q))  begin errors++; $display("FAIL rnd_jk_cell: cyc %0d got %0d expected %0d", k, m_cell, m_q); end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_hold();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
